// File: rtl/quant_pkg.sv
// rtl/quant_pkg.sv - shared tables and helpers for the 4x4 quant/recon path
// Purpose: multiplier tables (MF, V), position classes, QP decode and the
// rounding constants used by the quantize, rescale and inverse-transform stages.
// Ports: none (package).
package quant_pkg;

   localparam int unsigned QP_MAX     = 51;
   localparam int unsigned QBITS_BASE = 15;
   localparam int          RES_ROUND  = 32;
   localparam int          RES_SHIFT  = 6;

   typedef enum logic [1:0] {
      POS_A = 2'd0,
      POS_B = 2'd1,
      POS_C = 2'd2
   } pos_class_e;

   typedef struct packed {
      logic [3:0] div;
      logic [2:0] rem;
   } qp_dec_t;

   // Class A: even row and even column; B: odd row and odd column; C: the rest.
   function automatic pos_class_e pos_class(input logic [3:0] idx);
      case (idx)
         4'd0, 4'd2, 4'd8, 4'd10:  pos_class = POS_A;
         4'd5, 4'd7, 4'd13, 4'd15: pos_class = POS_B;
         default:                  pos_class = POS_C;
      endcase
   endfunction

   // Out-of-range QP saturates to the top of the legal range.
   function automatic qp_dec_t qp_decode(input logic [5:0] qp);
      logic [5:0] q;
      q = (qp > 6'(QP_MAX)) ? 6'(QP_MAX) : qp;
      qp_decode.div = 4'(q / 6'd6);
      qp_decode.rem = 3'(q % 6'd6);
   endfunction

   function automatic logic [13:0] mf_lookup(input logic [2:0] rem, input pos_class_e cls);
      logic [13:0] a;
      logic [13:0] b;
      logic [13:0] c;
      case (rem)
         3'd0:    begin a = 14'd13107; b = 14'd5243; c = 14'd8066; end
         3'd1:    begin a = 14'd11916; b = 14'd4660; c = 14'd7490; end
         3'd2:    begin a = 14'd10082; b = 14'd4194; c = 14'd6554; end
         3'd3:    begin a = 14'd9362;  b = 14'd3647; c = 14'd5825; end
         3'd4:    begin a = 14'd8192;  b = 14'd3355; c = 14'd5243; end
         default: begin a = 14'd7282;  b = 14'd2893; c = 14'd4559; end
      endcase
      case (cls)
         POS_A:   mf_lookup = a;
         POS_B:   mf_lookup = b;
         default: mf_lookup = c;
      endcase
   endfunction

   function automatic logic [4:0] v_lookup(input logic [2:0] rem, input pos_class_e cls);
      logic [4:0] a;
      logic [4:0] b;
      logic [4:0] c;
      case (rem)
         3'd0:    begin a = 5'd10; b = 5'd16; c = 5'd13; end
         3'd1:    begin a = 5'd11; b = 5'd18; c = 5'd14; end
         3'd2:    begin a = 5'd13; b = 5'd20; c = 5'd16; end
         3'd3:    begin a = 5'd14; b = 5'd23; c = 5'd18; end
         3'd4:    begin a = 5'd16; b = 5'd25; c = 5'd20; end
         default: begin a = 5'd18; b = 5'd29; c = 5'd23; end
      endcase
      case (cls)
         POS_A:   v_lookup = a;
         POS_B:   v_lookup = b;
         default: v_lookup = c;
      endcase
   endfunction

   // Rounding offset f: floor(2^qbits/3) for intra, floor(2^qbits/6) for inter.
   // qdiv has only 9 legal values, so this folds to a small constant table.
   function automatic logic [63:0] round_const(input logic [3:0] qdiv, input logic mode);
      logic [63:0] span;
      span = 64'd1 << (6'(QBITS_BASE) + {2'b00, qdiv});
      round_const = mode ? (span / 64'd6) : (span / 64'd3);
   endfunction

endpackage

// File: rtl/dequant_stage.sv
// rtl/dequant_stage.sv - inverse quantization (rescale) of a 4x4 level block
// Purpose: W' = (Z * V) << qp_div per element (combinational, signed).
// Ports: levels[16] in, qp_div/qp_rem decoded QP, coeffs[16] out
//        (truncated to element width).
module dequant_stage
   import quant_pkg::*;
#(
   parameter int BIT_LENGTH = 31
) (
   input  logic signed [BIT_LENGTH:0] levels [16],
   input  logic        [3:0]          qp_div,
   input  logic        [2:0]          qp_rem,
   output logic signed [BIT_LENGTH:0] coeffs [16]
);

   function automatic logic signed [BIT_LENGTH:0] rescale(
      input logic signed [BIT_LENGTH:0] z,
      input logic        [4:0]          v,
      input logic        [3:0]          qd
   );
      logic signed [63:0] prod;
      prod    = 64'(z) * $signed({59'd0, v});
      prod    = prod <<< qd;
      rescale = prod[BIT_LENGTH:0];
   endfunction

   always_comb begin
      coeffs = '{default: '0};
      for (int i = 0; i < 16; i++) begin
         coeffs[i] = rescale(levels[i], v_lookup(qp_rem, pos_class(4'(i))), qp_div);
      end
   end

endmodule

// File: rtl/idct_stage.sv
// rtl/idct_stage.sv - 4x4 integer inverse core transform, two register ranks
// Purpose: row butterflies registered, then column butterflies plus the
// (x+32)>>>6 descale registered into the residual output.
// Ports: clk, reset (sync, active-high), in_valid + coeffs[16] in,
//        out_valid + residuals[16] out; residuals hold across bubbles.
module idct_stage
   import quant_pkg::*;
#(
   parameter int BIT_LENGTH = 31
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       in_valid,
   input  logic signed [BIT_LENGTH:0] coeffs    [16],
   output logic                       out_valid,
   output logic signed [BIT_LENGTH:0] residuals [16]
);

   // Each butterfly pass grows magnitude by at most 3.5x, so six guard bits
   // keep both passes exact before the final descale and truncation.
   localparam int XW = BIT_LENGTH + 7;
   typedef logic signed [XW-1:0] wide_t;

   wide_t                       row_d  [16];
   wide_t                       row_q  [16];
   logic                        row_valid_d;
   logic                        row_valid_q;
   wide_t                       col    [4];
   logic signed [BIT_LENGTH:0]  res_d  [16];
   logic signed [BIT_LENGTH:0]  res_q  [16];
   logic                        out_valid_d;
   logic                        out_valid_q;

   function automatic void butterfly(
      input  wide_t a, input  wide_t b, input  wide_t c, input  wide_t d,
      output wide_t o0, output wide_t o1, output wide_t o2, output wide_t o3
   );
      wide_t e;
      wide_t f;
      wide_t g;
      wide_t h;
      e  = a + c;
      f  = a - c;
      g  = (b >>> 1) - d;
      h  = b + (d >>> 1);
      o0 = e + h;
      o1 = f + g;
      o2 = f - g;
      o3 = e - h;
   endfunction

   function automatic logic signed [BIT_LENGTH:0] descale(input wide_t x);
      wide_t t;
      t       = (x + wide_t'(RES_ROUND)) >>> RES_SHIFT;
      descale = t[BIT_LENGTH:0];
   endfunction

   always_comb begin
      row_d       = '{default: '0};
      row_valid_d = in_valid;
      for (int r = 0; r < 4; r++) begin
         butterfly(wide_t'(coeffs[4*r]),   wide_t'(coeffs[4*r+1]),
                   wide_t'(coeffs[4*r+2]), wide_t'(coeffs[4*r+3]),
                   row_d[4*r], row_d[4*r+1], row_d[4*r+2], row_d[4*r+3]);
      end
   end

   always_comb begin
      col         = '{default: '0};
      res_d       = res_q;
      out_valid_d = row_valid_q;
      if (row_valid_q) begin
         for (int c = 0; c < 4; c++) begin
            butterfly(row_q[c], row_q[4+c], row_q[8+c], row_q[12+c],
                      col[0], col[1], col[2], col[3]);
            for (int k = 0; k < 4; k++) begin
               res_d[4*k+c] = descale(col[k]);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         row_q       <= '{default: '0};
         row_valid_q <= 1'b0;
         res_q       <= '{default: '0};
         out_valid_q <= 1'b0;
      end else begin
         row_q       <= row_d;
         row_valid_q <= row_valid_d;
         res_q       <= res_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out_valid = out_valid_q;
   assign residuals = res_q;

endmodule

// File: rtl/quant_stage.sv
// rtl/quant_stage.sv - forward quantization of a 4x4 coefficient block
// Purpose: Z = sign(W) * ((|W|*MF + f) >> qbits) per element (combinational).
// Ports: coeffs[16] in, qp_div/qp_rem decoded QP, mode rounding select,
//        levels[16] out (truncated to element width).
module quant_stage
   import quant_pkg::*;
#(
   parameter int BIT_LENGTH = 31
) (
   input  logic signed [BIT_LENGTH:0] coeffs [16],
   input  logic        [3:0]          qp_div,
   input  logic        [2:0]          qp_rem,
   input  logic                       mode,
   output logic signed [BIT_LENGTH:0] levels [16]
);

   logic [63:0] f_rnd;
   logic [5:0]  qbits;

   // Magnitude is taken in 64 bits so the most negative input still has a
   // representable absolute value; the sign is restored after the shift so
   // negative inputs round towards zero symmetrically with positive ones.
   function automatic logic signed [BIT_LENGTH:0] quantize(
      input logic signed [BIT_LENGTH:0] w,
      input logic        [13:0]         mf,
      input logic        [63:0]         f,
      input logic        [5:0]          qb
   );
      logic signed [63:0] w_ext;
      logic        [63:0] mag;
      logic        [63:0] scaled;
      w_ext  = 64'(w);
      mag    = (w_ext < 0) ? 64'(-w_ext) : 64'(w_ext);
      scaled = (mag * {50'd0, mf} + f) >> qb;
      if (w_ext < 0) begin
         scaled = -scaled;
      end
      quantize = scaled[BIT_LENGTH:0];
   endfunction

   always_comb begin
      levels = '{default: '0};
      f_rnd  = round_const(qp_div, mode);
      qbits  = 6'(QBITS_BASE) + {2'b00, qp_div};
      for (int i = 0; i < 16; i++) begin
         levels[i] = quantize(coeffs[i], mf_lookup(qp_rem, pos_class(4'(i))), f_rnd, qbits);
      end
   end

endmodule

// File: rtl/quant_recon_4x4.sv
// rtl/quant_recon_4x4.sv - 4x4 quantize / rescale / inverse-transform back-end
// Purpose: one block per cycle, fixed 3-cycle latency from the accepting edge
// to out_valid; levels are delayed to line up with their residuals.
// Ports: clk, reset (sync, active-high), in_valid, qp[5:0], mode, coeffs[16]
//        in; out_valid, levels[16], residuals[16] out.
module quant_recon_4x4
   import quant_pkg::*;
#(
   parameter int BIT_LENGTH = 31
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       in_valid,
   input  logic        [5:0]          qp,
   input  logic                       mode,
   input  logic signed [BIT_LENGTH:0] coeffs    [16],
   output logic                       out_valid,
   output logic signed [BIT_LENGTH:0] levels    [16],
   output logic signed [BIT_LENGTH:0] residuals [16]
);

   qp_dec_t                    qp_in;
   logic signed [BIT_LENGTH:0] z_comb    [16];
   logic signed [BIT_LENGTH:0] w_comb    [16];

   // Rank 1: quantized levels plus the decoded QP needed by the rescale.
   logic                       vld1_d,  vld1_q;
   qp_dec_t                    qdec1_d, qdec1_q;
   logic signed [BIT_LENGTH:0] lvl1_d    [16];
   logic signed [BIT_LENGTH:0] lvl1_q    [16];
   // Rank 2: rescaled coefficients feeding the transform.
   logic                       vld2_d,  vld2_q;
   logic signed [BIT_LENGTH:0] dq2_d     [16];
   logic signed [BIT_LENGTH:0] dq2_q     [16];
   logic signed [BIT_LENGTH:0] lvl2_d    [16];
   logic signed [BIT_LENGTH:0] lvl2_q    [16];
   // Rank 3 runs alongside the transform's row register; the output rank
   // holds its value across bubbles just like the residual register does.
   logic                       vld3_d,  vld3_q;
   logic signed [BIT_LENGTH:0] lvl3_d    [16];
   logic signed [BIT_LENGTH:0] lvl3_q    [16];
   logic signed [BIT_LENGTH:0] lvl_out_d [16];
   logic signed [BIT_LENGTH:0] lvl_out_q [16];

   assign qp_in = qp_decode(qp);

   quant_stage #(.BIT_LENGTH(BIT_LENGTH)) u_quant (
      .coeffs (coeffs),
      .qp_div (qp_in.div),
      .qp_rem (qp_in.rem),
      .mode   (mode),
      .levels (z_comb)
   );

   dequant_stage #(.BIT_LENGTH(BIT_LENGTH)) u_dequant (
      .levels (lvl1_q),
      .qp_div (qdec1_q.div),
      .qp_rem (qdec1_q.rem),
      .coeffs (w_comb)
   );

   idct_stage #(.BIT_LENGTH(BIT_LENGTH)) u_idct (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (vld2_q),
      .coeffs    (dq2_q),
      .out_valid (out_valid),
      .residuals (residuals)
   );

   always_comb begin
      vld1_d    = in_valid;
      qdec1_d   = qp_in;
      lvl1_d    = z_comb;
      vld2_d    = vld1_q;
      dq2_d     = w_comb;
      lvl2_d    = lvl1_q;
      vld3_d    = vld2_q;
      lvl3_d    = lvl2_q;
      lvl_out_d = lvl_out_q;
      if (vld3_q) begin
         lvl_out_d = lvl3_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         vld1_q    <= 1'b0;
         qdec1_q   <= '0;
         lvl1_q    <= '{default: '0};
         vld2_q    <= 1'b0;
         dq2_q     <= '{default: '0};
         lvl2_q    <= '{default: '0};
         vld3_q    <= 1'b0;
         lvl3_q    <= '{default: '0};
         lvl_out_q <= '{default: '0};
      end else begin
         vld1_q    <= vld1_d;
         qdec1_q   <= qdec1_d;
         lvl1_q    <= lvl1_d;
         vld2_q    <= vld2_d;
         dq2_q     <= dq2_d;
         lvl2_q    <= lvl2_d;
         vld3_q    <= vld3_d;
         lvl3_q    <= lvl3_d;
         lvl_out_q <= lvl_out_d;
      end
   end

   assign levels = lvl_out_q;

endmodule

// File: tb/tb_quant_recon_4x4.sv
// tb/tb_quant_recon_4x4.sv - self-checking bench for quant_recon_4x4
module tb_quant_recon_4x4;

   localparam int BL = 31;

   logic                clk = 1'b0;
   logic                reset;
   logic                in_valid;
   logic [5:0]          qp;
   logic                mode;
   logic signed [BL:0]  coeffs    [16];
   logic                out_valid;
   logic signed [BL:0]  levels    [16];
   logic signed [BL:0]  residuals [16];

   always #5 clk = ~clk;

   quant_recon_4x4 #(.BIT_LENGTH(BL)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .qp        (qp),
      .mode      (mode),
      .coeffs    (coeffs),
      .out_valid (out_valid),
      .levels    (levels),
      .residuals (residuals)
   );

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      int v;
      int lv [16];
      int rs [16];
   } blk_t;

   typedef struct {
      int qp;
      int md;
      int idx;
      int val;
      int exp_lvl;
      int exp_res0;
      int exp_res15;
   } vec_t;

   blk_t pipe [$];
   int   exp_valid;
   int   exp_lv [16];
   int   exp_rs [16];

   int mf_t [6][3] = '{'{13107, 5243, 8066}, '{11916, 4660, 7490}, '{10082, 4194, 6554},
                       '{9362, 3647, 5825},  '{8192, 3355, 5243},  '{7282, 2893, 4559}};
   int v_t  [6][3] = '{'{10, 16, 13}, '{11, 18, 14}, '{13, 20, 16},
                       '{14, 23, 18}, '{16, 25, 20}, '{18, 29, 23}};

   function automatic int cls_of(input int i);
      int r, c;
      r = i / 4;
      c = i % 4;
      if ((r % 2 == 0) && (c % 2 == 0)) return 0;
      if ((r % 2 == 1) && (c % 2 == 1)) return 1;
      return 2;
   endfunction

   // Expanded 1-D inverse transform written as explicit sums.
   function automatic void tr4(input longint x0, input longint x1, input longint x2, input longint x3,
                               output longint y0, output longint y1, output longint y2, output longint y3);
      y0 = x0 + x2 + x1 + (x3 >>> 1);
      y1 = x0 - x2 + (x1 >>> 1) - x3;
      y2 = x0 - x2 - (x1 >>> 1) + x3;
      y3 = x0 + x2 - x1 - (x3 >>> 1);
   endfunction

   function automatic void ref_block(input int qpv, input int md, input int c [16],
                                     output int lv [16], output int rs [16]);
      int     q, qd, qm, qb, k;
      longint f, a, z;
      longint m [4][4];
      longint t [4][4];
      longint o [4][4];
      q  = (qpv > 51) ? 51 : qpv;
      qd = q / 6;
      qm = q % 6;
      qb = 15 + qd;
      f  = (longint'(1) << qb) / (md != 0 ? 6 : 3);
      for (int i = 0; i < 16; i++) begin
         k = cls_of(i);
         a = (c[i] < 0) ? -longint'(c[i]) : longint'(c[i]);
         z = (a * mf_t[qm][k] + f) >> qb;
         if (c[i] < 0) z = -z;
         lv[i] = int'(z);
         m[i/4][i%4] = longint'(int'(longint'(lv[i]) * v_t[qm][k] * (longint'(1) << qd)));
      end
      for (int r = 0; r < 4; r++)
         tr4(m[r][0], m[r][1], m[r][2], m[r][3], t[r][0], t[r][1], t[r][2], t[r][3]);
      for (int j = 0; j < 4; j++)
         tr4(t[0][j], t[1][j], t[2][j], t[3][j], o[0][j], o[1][j], o[2][j], o[3][j]);
      for (int i = 0; i < 16; i++)
         rs[i] = int'((o[i/4][i%4] + 32) >>> 6);
   endfunction

   task automatic check_int(input string name, input logic signed [63:0] act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_vec(input string name, input logic signed [BL:0] act [16], input int exp [16]);
      int bad;
      bad = -1;
      n_checks++;
      for (int i = 0; i < 16; i++)
         if (bad < 0 && act[i] !== exp[i]) bad = i;
      if (bad >= 0) begin
         n_fail++;
         $display("FAIL %s[%0d]: got %0d expected %0d", name, bad, act[bad], exp[bad]);
      end
   endtask

   function automatic blk_t empty_blk();
      blk_t b;
      b.v  = 0;
      b.lv = '{default: 0};
      b.rs = '{default: 0};
      return b;
   endfunction

   // Advance one clock: model the accepting edge, then compare every output.
   task automatic cycle();
      blk_t b, o;
      int   cc [16];
      int   lv [16];
      int   rs [16];
      b = empty_blk();
      if (in_valid && !reset) begin
         for (int i = 0; i < 16; i++) cc[i] = int'(coeffs[i]);
         ref_block(int'(qp), int'(mode), cc, lv, rs);
         b.v  = 1;
         b.lv = lv;
         b.rs = rs;
      end
      @(posedge clk);
      #1;
      if (reset) begin
         pipe.delete();
         repeat (3) pipe.push_back(empty_blk());
         exp_valid = 0;
         exp_lv    = '{default: 0};
         exp_rs    = '{default: 0};
      end else begin
         pipe.push_back(b);
         o = pipe.pop_front();
         exp_valid = o.v;
         if (o.v != 0) begin
            exp_lv = o.lv;
            exp_rs = o.rs;
         end
      end
      check_int("out_valid", out_valid, exp_valid);
      check_vec("levels", levels, exp_lv);
      check_vec("residuals", residuals, exp_rs);
   endtask

   task automatic drive(input logic v, input int q, input int md, input int idx, input int val);
      in_valid = v;
      qp       = 6'(q);
      mode     = md[0];
      coeffs   = '{default: '0};
      coeffs[idx] = val;
   endtask

   vec_t vecs [7];
   int   ghosts;
   int   sel;

   initial begin
      vecs[0] = '{28, 0, 0, 100, 1, 4, 4};
      vecs[1] = '{28, 0, 0, -100, -1, -4, -4};
      vecs[2] = '{0, 0, 0, 2, 1, 0, 0};
      vecs[3] = '{0, 1, 0, 2, 0, 0, 0};
      vecs[4] = '{0, 0, 5, 1000, 160, 40, 40};
      vecs[5] = '{60, 1, 0, 100000, 111, 6216, 6216};
      vecs[6] = '{12, 0, 1, 500, 31, 25, -25};

      repeat (3) pipe.push_back(empty_blk());
      exp_valid = 0;
      exp_lv    = '{default: 0};
      exp_rs    = '{default: 0};

      // Reset wins over a valid, nonzero block.
      reset = 1'b1;
      drive(1'b1, 28, 0, 0, 12345);
      for (int i = 0; i < 16; i++) coeffs[i] = 1000 * (i + 1);
      for (int c = 0; c < 4; c++) begin
         cycle();
         check_int("reset_out_valid", out_valid, 0);
         check_int("reset_level0", levels[0], 0);
         check_int("reset_residual0", residuals[0], 0);
      end
      reset = 1'b0;

      // Directed table: single block, then three bubbles, then check.
      for (int n = 0; n < 7; n++) begin
         drive(1'b1, vecs[n].qp, vecs[n].md, vecs[n].idx, vecs[n].val);
         cycle();
         drive(1'b0, 0, 0, 0, 0);
         cycle();
         cycle();
         check_int("vec_latency_early", out_valid, 0);
         cycle();
         check_int("vec_out_valid", out_valid, 1);
         check_int("vec_level", levels[vecs[n].idx], vecs[n].exp_lvl);
         check_int("vec_res0", residuals[0], vecs[n].exp_res0);
         check_int("vec_res15", residuals[15], vecs[n].exp_res15);
         cycle();
         check_int("vec_hold_level", levels[vecs[n].idx], vecs[n].exp_lvl);
      end

      // Blocks with a bubble, then reset with blocks in flight.
      drive(1'b1, 28, 0, 0, 100); cycle();
      drive(1'b0, 28, 0, 0, 0);   cycle();
      drive(1'b1, 28, 0, 0, 200); cycle();
      drive(1'b1, 28, 0, 0, 300); cycle();
      check_int("seq_b1_valid", out_valid, 1);
      check_int("seq_b1_level", levels[0], 1);
      drive(1'b1, 28, 0, 0, 400); cycle();
      check_int("seq_bubble_valid", out_valid, 0);
      check_int("seq_bubble_hold", levels[0], 1);
      drive(1'b1, 28, 0, 0, 500); cycle();
      check_int("seq_b2_level", levels[0], 3);
      reset = 1'b1;
      drive(1'b1, 28, 0, 0, 600); cycle();
      check_int("seq_reset_valid", out_valid, 0);
      reset = 1'b0;
      drive(1'b0, 0, 0, 0, 0);
      ghosts = 0;
      repeat (5) begin
         cycle();
         if (out_valid === 1'b1) ghosts++;
      end
      check_int("seq_no_ghost", ghosts, 0);
      drive(1'b1, 28, 0, 0, -100); cycle();
      drive(1'b0, 0, 0, 0, 0);
      cycle();
      cycle();
      cycle();
      check_int("seq_after_reset_level", levels[0], -1);
      check_int("seq_after_reset_res", residuals[5], -4);

      // Randomized traffic against the reference model.
      for (int n = 0; n < 400; n++) begin
         reset    = ($urandom_range(0, 59) == 0);
         in_valid = ($urandom_range(0, 4) != 0);
         qp       = 6'($urandom_range(0, 63));
         mode     = 1'($urandom_range(0, 1));
         sel      = $urandom_range(0, 2);
         for (int i = 0; i < 16; i++) begin
            if (sel == 0)      coeffs[i] = $signed(32'($urandom_range(0, 600))) - 300;
            else if (sel == 1) coeffs[i] = $signed(32'($urandom_range(0, 2097152))) - 1048576;
            else               coeffs[i] = $signed($urandom);
         end
         cycle();
      end
      reset = 1'b0;
      drive(1'b0, 0, 0, 0, 0);
      repeat (4) cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/quant_recon_4x4.md
Name: quant_recon_4x4

Overview:
- H.264 4x4 residual back-end: forward quantization, inverse quantization (rescale) and inverse core transform of one 4x4 block of forward-transformed coefficients.
- Sits after the forward 4x4 integer transform in the transform-coding path.
- Emits quantized levels (to entropy coding) and reconstructed residuals (to the reconstruction loop).
- 3-stage pipeline, one block per cycle.

Parameters:
- BIT_LENGTH, 31, MSB index of every coefficient/level/residual; element width is BIT_LENGTH+1, two's complement.

Ports:
- clk  in  1  clock, all logic on posedge
- reset  in  1  reset, synchronous, active-high; clock clk
- in_valid  in  1  coefficient block valid this cycle
- qp  in  6  quantization parameter 0..51; values >51 treated as 51
- mode  in  1  rounding mode: 0 = intra, f = 2^qbits/3; 1 = inter, f = 2^qbits/6
- coeffs  in  [BIT_LENGTH:0] x16  signed transformed coefficients; index i = row i/4, column i%4
- out_valid  out  1  levels/residuals valid
- levels  out  [BIT_LENGTH:0] x16  signed quantized levels, same indexing
- residuals  out  [BIT_LENGTH:0] x16  signed reconstructed residuals, same indexing

Behaviour:
- Reset: out_valid, levels, residuals and all pipeline registers cleared to 0 on the posedge where reset=1. Reset wins over in_valid.
- QP decode is combinational: qp_div = qp/6 (0..8), qp_mod = qp%6 (0..5). qp, mode and coeffs are sampled with in_valid at stage 1 and travel with the block.
- Position class:
  - A = indices 0, 2, 8, 10
  - B = indices 5, 7, 13, 15
  - C = all others
- Stage 1, forward quantization:
  - qbits = 15 + qp_div
  - Z = sign(W) * ((|W|*MF + f) >> qbits); sign of 0 is 0.
  - MF by qp_mod as (A, B, C): 0: 13107, 5243, 8066; 1: 11916, 4660, 7490; 2: 10082, 4194, 6554; 3: 9362, 3647, 5825; 4: 8192, 3355, 5243; 5: 7282, 2893, 4559.
  - f = floor(2^qbits/3) when mode=0, floor(2^qbits/6) when mode=1.
  - Products use at least 64-bit intermediates; the result is truncated to element width.
- Stage 2, inverse quantization:
  - W' = Z * V << qp_div (signed multiply, truncated to element width).
  - V by qp_mod as (A, B, C): 0: 10, 16, 13; 1: 11, 18, 14; 2: 13, 20, 16; 3: 14, 23, 18; 4: 16, 25, 20; 5: 18, 29, 23.
- Stage 3, inverse transform:
  - Horizontal pass on each row (a, b, c, d):
    - e = a+c, f = a−c, g = (b>>>1)−d, h = b+(d>>>1)
    - outputs e+h, f+g, f−g, e−h
  - Vertical pass: same butterfly on each column of the row-pass result.
  - r = (x+32)>>>6; all shifts arithmetic.
- Timing:
  - Latency is exactly 3 cycles: a block accepted at edge N appears with out_valid=1 after edge N+3.
  - Levels are delayed so the levels and residuals of the same block appear together.
  - Full throughput: back-to-back in_valid gives back-to-back out_valid, with no stalls and no backpressure.
- Bubbles: in_valid=0 inserts a bubble. out_valid=0 for that slot; levels/residuals hold their previous values.
- Reset mid-stream: every in-flight block is discarded; the first output after reset deasserts comes from the first block accepted after it.

Decomposition:
- Shared package quant_pkg:
  - MF and V tables (6x3)
  - function position-class(index)
  - QP div/mod function
  - rounding constants
- Sub-modules:
  - quant_stage: forward quantization
  - dequant_stage: inverse quantization
  - idct_stage: inverse transform, including the butterfly function
- Top level: the three stages plus the valid/QP/level alignment pipeline.

Test Plan:
- Reset asserted with in_valid=1 and nonzero coeffs -> out_valid=0, all levels/residuals 0 for every cycle of reset.
- qp=28, mode=0, coeffs[0]=100, rest 0 -> after 3 cycles levels[0]=1, other levels 0, all 16 residuals = 4.
- qp=28, mode=0, coeffs[0]=−100, rest 0 -> levels[0]=−1, all residuals = −4 (checks floor on negative rounding).
- qp=0, coeffs[0]=2, rest 0 -> levels[0]=1 with mode=0, levels[0]=0 with mode=1.
- qp=0, mode=0, coeffs[5]=1000, rest 0 -> levels[5]=160; internal dequantized value 2560.
- Three consecutive blocks with a one-cycle bubble, then reset asserted while two blocks are in flight -> outputs appear in order at exactly 3-cycle latency, out_valid low in the bubble slot, and no in-flight block emerges after reset.
